// File: rtl/ll_pkg.sv
// Shared types and constants for the multi-channel linked-list write controller.
package ll_pkg;

    localparam int LL_PTR_WD = 8;
    localparam int LL_CNT_WD = LL_PTR_WD + 1;
    localparam logic [LL_PTR_WD-1:0] NULL_PTR = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_PTR,
        ST_ISSUE,
        ST_WAIT_CMPL,
        ST_UPDATE
    } t_ll_wr_mc_st;

    typedef struct packed {
        logic [LL_PTR_WD-1:0] head;
        logic [LL_PTR_WD-1:0] tail;
        logic [LL_CNT_WD-1:0] cnt;
    } t_ll_list_rec;

endpackage

// File: rtl/ll_rr_arb.sv
// Round-robin arbiter: search starts one past the last accepted grant.
module ll_rr_arb #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      accept,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

    localparam int IDX_WD = $clog2(NUM_CH);

    logic [IDX_WD-1:0] rr_ptr;
    logic [IDX_WD-1:0] idx;
    logic              found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = IDX_WD'((int'(rr_ptr) + off) % NUM_CH);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept && |req) begin
            rr_ptr <= (gnt_idx == IDX_WD'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ll_wr_ctrl_mc.sv
// Multi-channel linked-list write controller: allocate node, write payload, link it, track lists.
// Optional LL_WR_CTRL_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on GET_PTR and WAIT_CMPL.
module ll_wr_ctrl_mc
    import ll_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_WD = 32,
    parameter int PTR_WD  = 8,
    parameter int CNT_WD  = PTR_WD + 1
`ifdef LL_WR_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_insert,
    input  logic [NUM_CH*DATA_WD-1:0] ch_data,
    input  logic [NUM_CH-1:0]         ch_clr,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic                      fp_req,
    input  logic                      fp_vld,
    input  logic [PTR_WD-1:0]         fp_ptr,
    input  logic                      fp_empty,
    output logic                      dm_wr_vld,
    output logic [PTR_WD-1:0]         dm_wr_addr,
    output logic [DATA_WD-1:0]        dm_wr_data,
    input  logic                      dm_wr_cmpl,
    output logic                      upd_nxt_ptr,
    output logic                      upd_nxt_ptr_insert,
    output logic [PTR_WD-1:0]         upd_node,
    output logic [PTR_WD-1:0]         upd_val,
    input  logic                      nxt_ptr_wr_done,
    output logic [NUM_CH*PTR_WD-1:0]  head_ptr,
    output logic [NUM_CH*PTR_WD-1:0]  tail_ptr,
    output logic [NUM_CH*CNT_WD-1:0]  list_cnt,
    output logic                      wr_done,
    output logic [$clog2(NUM_CH)-1:0] wr_done_ch,
    output logic                      wr_err,
    output logic                      ready
);

    localparam int IDX_WD = $clog2(NUM_CH);
    localparam logic [PTR_WD-1:0] NULL_P = '1;

    t_ll_wr_mc_st      state, next_state;
    logic [NUM_CH-1:0] gnt;
    logic [IDX_WD-1:0] gnt_idx, g_ch;
    logic [DATA_WD-1:0] g_data;
    logic              g_insert;
    logic [PTR_WD-1:0] new_ptr;
    logic              dm_done, np_done, clr_pend;
    logic              arb_accept, tmo_hit, abort, busy_clr, list_empty, both_done;

    logic [PTR_WD-1:0]  head_q [NUM_CH];
    logic [PTR_WD-1:0]  tail_q [NUM_CH];
    logic [CNT_WD-1:0]  cnt_q  [NUM_CH];
    logic [DATA_WD-1:0] ch_data_a [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_flat
        assign ch_data_a[i]                  = ch_data[i*DATA_WD +: DATA_WD];
        assign head_ptr[i*PTR_WD +: PTR_WD]  = head_q[i];
        assign tail_ptr[i*PTR_WD +: PTR_WD]  = tail_q[i];
        assign list_cnt[i*CNT_WD +: CNT_WD]  = cnt_q[i];
    end

    assign arb_accept = (state == ST_IDLE);

    ll_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (ch_req),
        .accept  (arb_accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef LL_WR_CTRL_TIMEOUT_EN
    localparam int TMO_WD = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_WD-1:0] tmo_cnt;

    // Counter restarts whenever the FSM leaves a waiting state, so each wait gets a full budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if ((state == ST_GET_PTR || state == ST_WAIT_CMPL) && next_state == state) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ST_GET_PTR || state == ST_WAIT_CMPL) &&
                     (tmo_cnt == TMO_WD'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign both_done  = (dm_done | dm_wr_cmpl) & (np_done | nxt_ptr_wr_done);
    assign list_empty = (cnt_q[g_ch] == '0);
    assign busy_clr   = (state != ST_IDLE) && ch_clr[g_ch];
    assign abort      = (state == ST_GET_PTR || state == ST_WAIT_CMPL) && (next_state == ST_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (|ch_req) next_state = ST_GET_PTR;
            ST_GET_PTR: begin
                if (fp_vld)       next_state = fp_empty ? ST_IDLE : ST_ISSUE;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_ISSUE:     next_state = ST_WAIT_CMPL;
            ST_WAIT_CMPL: begin
                if (both_done)    next_state = ST_UPDATE;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_UPDATE:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Link selection: an empty list gets a terminated node regardless of insert mode.
    always_comb begin
        upd_nxt_ptr        = (state == ST_ISSUE);
        upd_nxt_ptr_insert = 1'b0;
        upd_node           = new_ptr;
        upd_val            = NULL_P;
        if (!list_empty) begin
            if (g_insert) begin
                upd_nxt_ptr_insert = (state == ST_ISSUE);
                upd_val            = head_q[g_ch];
            end else begin
                upd_node = tail_q[g_ch];
                upd_val  = new_ptr;
            end
        end
    end

    assign ch_ack     = arb_accept ? gnt : '0;
    assign fp_req     = (state == ST_GET_PTR);
    assign dm_wr_vld  = (state == ST_ISSUE);
    assign dm_wr_addr = new_ptr;
    assign dm_wr_data = g_data;
    assign wr_done    = (state == ST_UPDATE);
    assign wr_done_ch = g_ch;
    assign wr_err     = abort;
    assign ready      = (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            g_ch     <= '0;
            g_data   <= '0;
            g_insert <= 1'b0;
            new_ptr  <= '0;
            dm_done  <= 1'b0;
            np_done  <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && |ch_req) begin
                g_ch     <= gnt_idx;
                g_data   <= ch_data_a[gnt_idx];
                g_insert <= ch_insert[gnt_idx];
            end
            if (state == ST_GET_PTR && fp_vld && !fp_empty) begin
                new_ptr <= fp_ptr;
            end
            if (state == ST_ISSUE || state == ST_WAIT_CMPL) begin
                dm_done <= dm_done | dm_wr_cmpl;
                np_done <= np_done | nxt_ptr_wr_done;
            end else begin
                dm_done <= 1'b0;
                np_done <= 1'b0;
            end
            if (next_state == ST_IDLE)  clr_pend <= 1'b0;
            else if (busy_clr)          clr_pend <= 1'b1;
        end
    end

    // A clear aimed at the in-flight list is deferred and folded into its completion or abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                head_q[i] <= NULL_P;
                tail_q[i] <= NULL_P;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i] && !(state != ST_IDLE && g_ch == IDX_WD'(i))) begin
                    head_q[i] <= NULL_P;
                    tail_q[i] <= NULL_P;
                    cnt_q[i]  <= '0;
                end
            end
            if (state == ST_UPDATE) begin
                if (clr_pend || ch_clr[g_ch] || list_empty) begin
                    head_q[g_ch] <= new_ptr;
                    tail_q[g_ch] <= new_ptr;
                    cnt_q[g_ch]  <= CNT_WD'(1);
                end else if (g_insert) begin
                    head_q[g_ch] <= new_ptr;
                    cnt_q[g_ch]  <= cnt_q[g_ch] + 1'b1;
                end else begin
                    tail_q[g_ch] <= new_ptr;
                    cnt_q[g_ch]  <= cnt_q[g_ch] + 1'b1;
                end
            end else if (abort && (clr_pend || ch_clr[g_ch])) begin
                head_q[g_ch] <= NULL_P;
                tail_q[g_ch] <= NULL_P;
                cnt_q[g_ch]  <= '0;
            end
        end
    end

endmodule
